multicycle_control_unit: RTL
============================

# multicycle_control_unit

Multi-cycle successor to the single-cycle MIPS opcode decoder: a registered FSM that sequences every instruction through IF/ID/EXE/MEM/WB. It drives all datapath control lines per state and decodes the same opcode set plus `jr` and `jal`. It keeps a sticky halt flag and a retired-instruction counter. It sits between the instruction register (`op`), the ALU (`zero`) and the PC, register file and memory enables.

## Interface
- `OP_W`, 6: opcode width. Opcode values below are given for 6 bits.
- `ALUOP_W`, 3: ALUOp width, minimum 3. Bits above [2] are driven 0.
- `CNT_W`, 32: width of the retired counter.
- `CLK` input 1: single clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `op` input OP_W: opcode from the external IR. Stable from ID until the next IF.
- `zero` input 1: ALU zero flag. Sampled combinationally in bEXE.
- `PCWre`, `IRWre`, `RegWre`, `mRD`, `mWR` output 1 each: write and read enables.
- `ALUSrcA`, `ALUSrcB`, `ExtSel`, `DBDataSrc`, `WrRegDSrc` output 1 each: datapath mux selects.
- `InsMemRW` output 1: constant 1 (instruction memory is read-only).
- `RegDst` output 2: write-register select. 00 = $31, 01 = rt, 10 = rd.
- `PCSrc` output 2: next-PC select. 00 = PC+4, 01 = branch target, 10 = rs (`jr`), 11 = jump target.
- `ALUOp` output ALUOP_W: ALU function. add 000, sub 001, sll 010, or 011, and 100, slt 101.
- `state` output 3: current FSM state.
- `halted` output 1: sticky halt flag.
- `retired` output CNT_W: count of instructions completed.

## Operation
- Opcodes: add 000000, addi 000001, sub 000010, ori 010000, and 010001, or 010010, sll 011000, slti 011011, sw 100110, lw 100111, beq 110000, bne 110001, j 111000, jr 111001, jal 111010, halt 111111.
- State encodings: IF 000, ID 001, aEXE 110, bEXE 101, cEXE 010, MEM 011, aWB 111, cWB 100.
- Default for every output not listed under a state is 0. `InsMemRW` is always 1.
- IF: `IRWre`=1. Next state is ID.
- ID, `j`: `PCWre`=1, `PCSrc`=11. Next state IF.
- ID, `jr`: `PCWre`=1, `PCSrc`=10. Next state IF.
- ID, `jal`: `PCWre`=1, `PCSrc`=11, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0. Next state IF.
- ID, `halt`: all enables 0. Sets `halted` and goes to IF.
- ID, undefined opcode: executes as a nop. `PCWre`=1, `PCSrc`=00, next state IF.
- ID, other opcodes: ALU ops go to aEXE, beq/bne to bEXE, lw/sw to cEXE.
- aEXE: `ALUOp` per opcode (ori→011). `ALUSrcA`=1 for sll only. `ALUSrcB`=1 for addi/ori/slti. `ExtSel`=1 for addi/slti. Next state aWB.
- aWB: same ALU controls as aEXE, plus `RegWre`=1, `WrRegDSrc`=1, `DBDataSrc`=0, `PCWre`=1, `PCSrc`=00.
- aWB `RegDst`: 10 for add/sub/and/or/sll, 01 for addi/ori/slti. Next state IF.
- bEXE: `ALUOp`=001, `ExtSel`=1, `PCWre`=1.
- bEXE `PCSrc`: 01 when (beq and `zero`) or (bne and not `zero`), else 00. Next state IF.
- cEXE: `ALUSrcB`=1, `ExtSel`=1, `ALUOp`=000. Next state MEM.
- MEM: holds the cEXE ALU controls. lw: `mRD`=1, next state cWB. sw: `mWR`=1, `PCWre`=1, next state IF.
- cWB: holds the cEXE ALU controls, plus `mRD`=1, `RegWre`=1, `DBDataSrc`=1, `WrRegDSrc`=1, `RegDst`=01, `PCWre`=1. Next state IF.
- `halted`=1: state stays IF and every enable is forced 0, including `IRWre`. Only `Reset` clears `halted`.
- `retired` increments by 1 on each edge where `PCWre`=1 and `Reset`=0. It wraps from 2^CNT_W−1 to 0.
- The `halt` instruction does not increment `retired`.

## Timing
- Edges where `Reset`=1 load `state`=IF (000), `halted`=0, `retired`=0.
- While `Reset`=1, outputs are combinationally gated: `PCWre`=`IRWre`=`RegWre`=`mRD`=`mWR`=0, all other outputs at their defaults.
- Reset asserted in any state, including mid-instruction, gives IF on the next cycle. No write is issued during the reset cycle.
- All outputs are combinational from (`state`, `op`, `zero`, `halted`, `Reset`). There are no output registers.
- Cycles per instruction, IF through the cycle with `PCWre`=1:
  - j / jr / jal / nop: 2
  - beq / bne: 3
  - ALU ops and sw: 4
  - lw: 5
- `PCWre` is high for exactly one cycle per instruction. `RegWre` is high for at most one cycle per instruction.

## Test plan
- Reset held for 2 cycles, then `op`=000000: `state` goes 000→001→110→111→000. In aWB, `RegWre`=1, `RegDst`=10, `PCWre`=1. `retired`=1 after the aWB edge.
- `op`=100111 (lw): 5-cycle sequence 000,001,010,011,100. `mRD`=1 in MEM and cWB. `DBDataSrc`=1 and `RegWre`=1 only in cWB.
- `op`=110000 in bEXE: with `zero`=1, `PCSrc`=01; with `zero`=0, `PCSrc`=00. Repeat with `op`=110001 and expect the inverse.
- `op`=111010 (jal) in ID: `PCSrc`=11, `RegWre`=1, `RegDst`=00, `WrRegDSrc`=0. Back to IF the next cycle.
- `op`=111111: `halted`=1 and `state` holds 000 with `IRWre`=0 for 10 cycles. `retired` is unchanged. Asserting `Reset` clears `halted`.
- Reset asserted during MEM of sw: `mWR`=0 in that cycle, `state`=000 and `retired`=0 next cycle. Also force `retired`=2^CNT_W−1 (CNT_W=4) and retire one instruction: `retired` wraps to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle MIPS control FSM. Each instruction is sequenced through
//   IF / ID / EXE / MEM / WB, and the datapath control lines are driven
//   for the current state. A sticky halt flag and a retired-instruction
//   counter are also kept.
//
// Ports
//   CLK, Reset      : rising-edge clock, synchronous active-high reset
//   op              : opcode from the external instruction register
//   zero            : ALU zero flag, used by beq/bne in bEXE
//   PCWre, IRWre, RegWre, mRD, mWR     : write/read enables
//   ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc : datapath mux selects
//   InsMemRW        : instruction memory read, tied to 1
//   RegDst          : 00 = $31, 01 = rt, 10 = rd
//   PCSrc           : 00 = PC+4, 01 = branch, 10 = rs, 11 = jump target
//   ALUOp           : ALU function code
//   state           : current FSM state
//   halted          : sticky halt flag
//   retired         : number of instructions completed (wraps)
module multicycle_control_unit #(
    parameter int unsigned OP_W    = 6,
    parameter int unsigned ALUOP_W = 3,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [OP_W-1:0]    op,
    input  logic               zero,
    output logic               PCWre,
    output logic               IRWre,
    output logic               RegWre,
    output logic               mRD,
    output logic               mWR,
    output logic               ALUSrcA,
    output logic               ALUSrcB,
    output logic               ExtSel,
    output logic               DBDataSrc,
    output logic               WrRegDSrc,
    output logic               InsMemRW,
    output logic [1:0]         RegDst,
    output logic [1:0]         PCSrc,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic [2:0]         state,
    output logic               halted,
    output logic [CNT_W-1:0]   retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_CEXE = 3'b010,
        S_MEM  = 3'b011,
        S_CWB  = 3'b100,
        S_BEXE = 3'b101,
        S_AEXE = 3'b110,
        S_AWB  = 3'b111
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_SUB  = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'b010000);
    localparam logic [OP_W-1:0] OP_AND  = OP_W'(6'b010001);
    localparam logic [OP_W-1:0] OP_OR   = OP_W'(6'b010010);
    localparam logic [OP_W-1:0] OP_SLL  = OP_W'(6'b011000);
    localparam logic [OP_W-1:0] OP_SLTI = OP_W'(6'b011011);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b100110);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100111);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b110000);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'b110001);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b111000);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(6'b111001);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'b111010);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(6'b111111);

    state_t             state_q, state_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic               is_lw, is_sw, is_beq, is_bne;
    logic               is_alu, is_alu_imm, is_br, is_mem;
    logic [2:0]         alu_fn;
    logic               alu_srca, alu_srcb, alu_ext;
    logic [2:0]         aluop3;

    assign is_lw      = (op == OP_LW);
    assign is_sw      = (op == OP_SW);
    assign is_beq     = (op == OP_BEQ);
    assign is_bne     = (op == OP_BNE);
    assign is_alu_imm = (op == OP_ADDI) || (op == OP_ORI) || (op == OP_SLTI);
    assign is_alu     = is_alu_imm || (op == OP_ADD) || (op == OP_SUB) ||
                        (op == OP_AND) || (op == OP_OR) || (op == OP_SLL);
    assign is_br      = is_beq || is_bne;
    assign is_mem     = is_lw || is_sw;

    // ALU controls shared by aEXE and aWB
    always_comb begin
        alu_fn   = 3'b000;
        alu_srca = 1'b0;
        alu_srcb = 1'b0;
        alu_ext  = 1'b0;
        unique case (op)
            OP_ADDI: begin alu_srcb = 1'b1; alu_ext = 1'b1; end
            OP_SUB:  alu_fn = 3'b001;
            OP_SLL:  begin alu_fn = 3'b010; alu_srca = 1'b1; end
            OP_OR:   alu_fn = 3'b011;
            OP_ORI:  begin alu_fn = 3'b011; alu_srcb = 1'b1; end
            OP_AND:  alu_fn = 3'b100;
            OP_SLTI: begin alu_fn = 3'b101; alu_srcb = 1'b1; alu_ext = 1'b1; end
            default: ;
        endcase
    end

    // Outputs and next state. Reset and halted take priority over the
    // state decode, so no enable can be raised during a reset cycle.
    always_comb begin
        state_d   = state_q;
        halted_d  = halted_q;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        mRD       = 1'b0;
        mWR       = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b00;
        PCSrc     = 2'b00;
        aluop3    = 3'b000;

        if (Reset) begin
            state_d  = S_IF;
            halted_d = 1'b0;
        end else if (halted_q) begin
            state_d = S_IF;
        end else begin
            case (state_q)
                S_IF: begin
                    IRWre   = 1'b1;
                    state_d = S_ID;
                end
                S_ID: begin
                    state_d = S_IF;
                    if (op == OP_J) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                    end else if (op == OP_JR) begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end else if (op == OP_JAL) begin
                        PCWre  = 1'b1;
                        PCSrc  = 2'b11;
                        RegWre = 1'b1;
                        RegDst = 2'b00;
                    end else if (op == OP_HALT) begin
                        halted_d = 1'b1;
                    end else if (is_alu) begin
                        state_d = S_AEXE;
                    end else if (is_br) begin
                        state_d = S_BEXE;
                    end else if (is_mem) begin
                        state_d = S_CEXE;
                    end else begin
                        // undefined opcode retires as a nop
                        PCWre = 1'b1;
                    end
                end
                S_AEXE: begin
                    aluop3  = alu_fn;
                    ALUSrcA = alu_srca;
                    ALUSrcB = alu_srcb;
                    ExtSel  = alu_ext;
                    state_d = S_AWB;
                end
                S_AWB: begin
                    aluop3    = alu_fn;
                    ALUSrcA   = alu_srca;
                    ALUSrcB   = alu_srcb;
                    ExtSel    = alu_ext;
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    PCWre     = 1'b1;
                    RegDst    = is_alu_imm ? 2'b01 : 2'b10;
                    state_d   = S_IF;
                end
                S_BEXE: begin
                    aluop3  = 3'b001;
                    ExtSel  = 1'b1;
                    PCWre   = 1'b1;
                    PCSrc   = ((is_beq && zero) || (is_bne && !zero)) ? 2'b01 : 2'b00;
                    state_d = S_IF;
                end
                S_CEXE: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    state_d = S_MEM;
                end
                S_MEM: begin
                    ALUSrcB = 1'b1;
                    ExtSel  = 1'b1;
                    if (is_lw) begin
                        mRD     = 1'b1;
                        state_d = S_CWB;
                    end else begin
                        mWR     = is_sw;
                        PCWre   = is_sw;
                        state_d = S_IF;
                    end
                end
                S_CWB: begin
                    ALUSrcB   = 1'b1;
                    ExtSel    = 1'b1;
                    mRD       = 1'b1;
                    RegWre    = 1'b1;
                    DBDataSrc = 1'b1;
                    WrRegDSrc = 1'b1;
                    RegDst    = 2'b01;
                    PCWre     = 1'b1;
                    state_d   = S_IF;
                end
                default: state_d = S_IF;
            endcase
        end

        retired_d = Reset ? '0 : retired_q + CNT_W'(PCWre);
    end

    always_ff @(posedge CLK) begin
        state_q   <= state_d;
        halted_q  <= halted_d;
        retired_q <= retired_d;
    end

    assign InsMemRW = 1'b1;
    assign ALUOp    = ALUOP_W'(aluop3);
    assign state    = state_q;
    assign halted   = halted_q;
    assign retired  = retired_q;

endmodule
